// File: rtl/counter_scheduler_pkg.sv
// Shared definitions for the counter time-slice scheduler: FSM states, engine indices, round-robin helpers.
package counter_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int NUM_ENG     = 3;
  localparam int ENG_DOWN    = 0;
  localparam int ENG_UP      = 1;
  localparam int ENG_JOHNSON = 2;

  typedef logic [1:0] eng_idx_t;

  function automatic eng_idx_t rr_next(input eng_idx_t idx);
    return (idx == eng_idx_t'(NUM_ENG - 1)) ? eng_idx_t'(0) : idx + eng_idx_t'(1);
  endfunction

  // First requester at or after ptr, wrapping; returns ptr when nobody requests.
  function automatic eng_idx_t rr_pick(input logic [NUM_ENG-1:0] req, input eng_idx_t ptr);
    eng_idx_t idx;
    eng_idx_t pick;
    logic     found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = rr_next(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/counter_scheduler_tick_prescaler.sv
// tick_prescaler: counts 0..DIV_MAX while enabled, synchronous clear, holds otherwise.
// tc_o is a combinational one-cycle pulse on the enabled terminal-count cycle.
module tick_prescaler #(
  parameter int DIV_MAX = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(DIV_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin time-slicing of one prescaled tick and one 4-bit display among three counter engines.
// Optional COUNTER_SCHED_PAUSE_EN: pause_i freezes prescaler, slot count and tick while in RUN.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int DIV_MAX    = 25_000_000,
  parameter int SLOT_TICKS = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic [NUM_ENG-1:0] req_i,
  input  logic [3:0]         eng_q0_i,
  input  logic [3:0]         eng_q1_i,
  input  logic [3:0]         eng_q2_i,
  output logic [NUM_ENG-1:0] grant_o,
  output logic               tick_o,
  output logic [3:0]         q_o,
  output logic               busy_o
);

  localparam logic [7:0] SLOT_LAST = 8'(SLOT_TICKS - 1);

  state_e             state_q, state_d;
  eng_idx_t           ptr_q, ptr_d;
  eng_idx_t           gidx_q, gidx_d;
  logic [NUM_ENG-1:0] grant_q, grant_d;
  logic [7:0]         slot_q, slot_d;
  logic [3:0]         q_q, q_d;

  logic     frozen;
  logic     tick_w;
  logic     run;
  eng_idx_t pick;
  logic [3:0] eng_sel;

`ifdef COUNTER_SCHED_PAUSE_EN
  assign frozen = pause_i;
`else
  logic unused_pause;
  assign unused_pause = pause_i;
  assign frozen       = 1'b0;
`endif

  assign run  = (state_q == ST_RUN);
  assign pick = rr_pick(req_i, ptr_q);

  // Gating with rst_i keeps a reset cycle from leaking a tick to the engine.
  tick_prescaler #(
    .DIV_MAX(DIV_MAX)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(state_q == ST_ARB),
    .en_i   (run && !frozen && !rst_i),
    .tc_o   (tick_w)
  );

  always_comb begin
    eng_sel = eng_q0_i;
    case (gidx_q)
      eng_idx_t'(ENG_DOWN):    eng_sel = eng_q0_i;
      eng_idx_t'(ENG_UP):      eng_sel = eng_q1_i;
      eng_idx_t'(ENG_JOHNSON): eng_sel = eng_q2_i;
      default:                 eng_sel = eng_q0_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    slot_d  = slot_q;
    q_d     = q_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (|req_i)) state_d = ST_ARB;
      end
      ST_ARB: begin
        slot_d = '0;
        if (|req_i) begin
          gidx_d  = pick;
          grant_d = NUM_ENG'(1) << pick;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        q_d = eng_sel;
        if (tick_w) slot_d = slot_q + 8'd1;
        // Expiry and a request drop in the same cycle share this single exit.
        if ((tick_w && (slot_q == SLOT_LAST)) || !req_i[gidx_q] || !start_i) begin
          ptr_d   = rr_next(gidx_q);
          grant_d = '0;
          state_d = start_i ? ST_ARB : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      slot_q  <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      slot_q  <= slot_d;
      q_q     <= q_d;
    end
  end

  assign grant_o = grant_q;
  assign tick_o  = tick_w;
  assign q_o     = q_q;
  assign busy_o  = (state_q == ST_ARB) || (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler with DIV_MAX=3, SLOT_TICKS=2: vector table, corner sequences, random run vs reference model.
module tb_counter_scheduler;

  localparam int DIV  = 3;
  localparam int SLOT = 2;
`ifdef COUNTER_SCHED_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic [2:0] req;
  logic [3:0] e0, e1, e2;
  logic [2:0] grant;
  logic       tick;
  logic [3:0] q;
  logic       busy;

  always #5 clk = ~clk;

  counter_scheduler #(.DIV_MAX(DIV), .SLOT_TICKS(SLOT)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .pause_i (pause),
    .req_i   (req),
    .eng_q0_i(e0),
    .eng_q1_i(e1),
    .eng_q2_i(e2),
    .grant_o (grant),
    .tick_o  (tick),
    .q_o     (q),
    .busy_o  (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus a count of unpaused RUN cycles spent in the current slot.
  int         m_phase;   // 0 idle, 1 arbitrating, 2 running
  int         m_ptr, m_gidx, m_elapsed;
  logic [2:0] m_grant;
  logic [3:0] m_q;

  function automatic bit m_paused();
    return PAUSE_EN && pause;
  endfunction

  function automatic bit m_tick();
    return (m_phase == 2) && !rst && !m_paused() && ((m_elapsed % (DIV + 1)) == DIV);
  endfunction

  function automatic int first_req(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) begin
      if (r[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [3:0] eng_of(input int i);
    return (i == 0) ? e0 : (i == 1) ? e1 : e2;
  endfunction

  task automatic model_step();
    bit t;
    int pick;
    t = m_tick();
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_gidx = 0; m_grant = 3'b000; m_q = 4'h0; m_elapsed = 0;
    end else if (m_phase == 0) begin
      if (start && req != 3'b000) m_phase = 1;
    end else if (m_phase == 1) begin
      pick = first_req(req, m_ptr);
      if (pick < 0) m_phase = 0;
      else begin
        m_gidx = pick; m_grant = 3'(1 << pick); m_elapsed = 0; m_phase = 2;
      end
    end else begin
      m_q = eng_of(m_gidx);
      if (!m_paused()) m_elapsed++;
      if ((t && m_elapsed == SLOT * (DIV + 1)) || !req[m_gidx] || !start) begin
        m_ptr   = (m_gidx + 1) % 3;
        m_grant = 3'b000;
        m_phase = start ? 1 : 0;
      end
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model();
    chk("grant", grant, m_grant);
    chk("tick", tick, m_tick());
    chk("q", q, m_q);
    chk("busy", busy, m_phase != 0);
  endtask

  task automatic step();
    settle();
    check_model();
    adv();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] grant;
    logic       tick;
    logic [3:0] q;
    logic       busy;
  } vec_t;

  vec_t tbl[15];
  int   first_tick;

  initial begin
    // Reset, first two-tick slot of engine 0, one-cycle gap, hand-off to engine 1.
    tbl[0]  = '{1'b1, 3'b111, 3'b000, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 3'b111, 3'b000, 1'b0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 3'b111, 3'b000, 1'b0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 3'b111, 3'b000, 1'b0, 4'h0, 1'b1};
    tbl[4]  = '{1'b0, 3'b111, 3'b001, 1'b0, 4'h0, 1'b1};
    tbl[5]  = '{1'b0, 3'b111, 3'b001, 1'b0, 4'h3, 1'b1};
    tbl[6]  = '{1'b0, 3'b111, 3'b001, 1'b0, 4'h3, 1'b1};
    tbl[7]  = '{1'b0, 3'b111, 3'b001, 1'b1, 4'h3, 1'b1};
    tbl[8]  = '{1'b0, 3'b111, 3'b001, 1'b0, 4'h3, 1'b1};
    tbl[9]  = '{1'b0, 3'b111, 3'b001, 1'b0, 4'h3, 1'b1};
    tbl[10] = '{1'b0, 3'b111, 3'b001, 1'b0, 4'h3, 1'b1};
    tbl[11] = '{1'b0, 3'b111, 3'b001, 1'b1, 4'h3, 1'b1};
    tbl[12] = '{1'b0, 3'b111, 3'b000, 1'b0, 4'h3, 1'b1};
    tbl[13] = '{1'b0, 3'b111, 3'b010, 1'b0, 4'h3, 1'b1};
    tbl[14] = '{1'b0, 3'b111, 3'b010, 1'b0, 4'h5, 1'b1};

    rst = 1'b1; start = 1'b1; pause = 1'b0; req = 3'b111;
    e0 = 4'h3; e1 = 4'h5; e2 = 4'h9;
    settle();
    adv();

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      settle();
      chk($sformatf("vec%0d_grant", i), grant, tbl[i].grant);
      chk($sformatf("vec%0d_tick", i), tick, tbl[i].tick);
      chk($sformatf("vec%0d_q", i), q, tbl[i].q);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      adv();
    end

    // Rotation continues through engine 2 and back to engine 0.
    for (int i = 0; i < 20; i++) step();

    // Sole requester: regranted after a one-cycle gap, q follows engine 1.
    do_reset();
    req = 3'b010;
    for (int i = 0; i < 30; i++) begin
      e1 = 4'($urandom_range(0, 15));
      step();
    end
    e1 = 4'h5;

    // Engine 0 drops its request after its first tick.
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 6; i++) step();
    req = 3'b110;
    step();
    settle();
    check_model();
    chk("drop_gap_grant", grant, 3'b000);
    adv();
    settle();
    check_model();
    chk("drop_regrant", grant, 3'b010);
    adv();

    // Reset in the middle of a slot with the prescaler at 2.
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    settle();
    check_model();
    chk("rst_cycle_tick", tick, 1'b0);
    adv();
    rst = 1'b0;
    settle();
    chk("post_rst_grant", grant, 3'b000);
    chk("post_rst_tick", tick, 1'b0);
    chk("post_rst_q", q, 4'h0);
    chk("post_rst_busy", busy, 1'b0);
    adv();

    // Pause for five RUN cycles right after the second prescaler count.
    do_reset();
    req = 3'b001;
    step();
    step();
    first_tick = -1;
    for (int i = 0; i < 20; i++) begin
      pause = (i >= 2 && i <= 6);
      settle();
      check_model();
      if (tick === 1'b1 && first_tick < 0) first_tick = i;
      adv();
    end
    pause = 1'b0;
    chk("pause_first_tick_idx", first_tick, PAUSE_EN ? 8 : 3);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 9) == 0) req = 3'($urandom_range(0, 7));
      pause = ($urandom_range(0, 5) == 0);
      e0 = 4'($urandom_range(0, 15));
      e1 = 4'($urandom_range(0, 15));
      e2 = 4'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
